dram_result_dumper: RTL and testbench

- Downstream stage of the matrix-multiplication processor. Once the processor signals end of process, this block reads the result matrix out of data memory (DRAM) byte by byte and serialises each byte onto a UART TX line (8N1).
- Shares the DRAM read port (address / q) with the processor. It only drives the address while busy; the top level muxes the address on busy.

---
 rtl/dram_result_dumper.sv | 164 ++++++++++++++++
 tb/tb_dram_result_dumper.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_result_dumper.sv
// dram_result_dumper
//   After the matrix-multiplication processor signals end of process, reads
//   LENGTH result bytes from DRAM starting at START_ADDR and sends each one
//   on a UART TX line (8N1, LSB first, CLKS_PER_BIT clocks per bit).
//
// Ports:
//   clock    system clock (same domain as processor and DRAM)
//   rst      synchronous active-high reset
//   start    dump request, sampled only in IDLE and DONE (end_process)
//   mem_q    DRAM read data, valid RD_LAT cycles after mem_addr changes
//   mem_addr DRAM read address (top level muxes it in while busy)
//   mem_wren DRAM write enable, always 0 (feeds the top-level mux)
//   tx       UART serial output, idle high, registered
//   busy     high from start acceptance until DONE is entered
//   done     high in DONE until the next accepted start or reset
//
// Per-byte timing: READ(1) + WAIT(RD_LAT) + 10 bit periods + NEXT(1).
// tx is a register that follows the state one cycle later, so tx falls
// RD_LAT+2 cycles after the edge that accepted start.

module dram_result_dumper #(
  parameter logic [15:0] START_ADDR   = 16'd0,
  parameter logic [15:0] LENGTH       = 16'd9,
  parameter logic [15:0] CLKS_PER_BIT = 16'd434,
  parameter logic [1:0]  RD_LAT       = 2'd1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  mem_q,
  output logic [15:0] mem_addr,
  output logic        mem_wren,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] byte_cnt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [1:0]  lat_cnt;
  logic [7:0]  shreg;
  logic        baud_tick;

  assign mem_wren  = 1'b0;
  assign baud_tick = (baud_cnt == CLKS_PER_BIT - 16'd1);

  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_addr <= START_ADDR;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      lat_cnt  <= '0;
      shreg    <= '0;
    end else begin
      // Line level is derived from the current state and registered, so the
      // serial output lags the state by one cycle and has no input path.
      case (state)
        START_BIT: tx <= 1'b0;
        DATA_BITS: tx <= shreg[0];
        default:   tx <= 1'b1;
      endcase

      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (LENGTH == 16'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= READ;
              busy     <= 1'b1;
              done     <= 1'b0;
              mem_addr <= START_ADDR;
              byte_cnt <= '0;
            end
          end
        end

        READ: begin
          state   <= WAIT;
          lat_cnt <= '0;
        end

        // mem_addr is untouched here, so it stays stable through the capture.
        WAIT: begin
          if (lat_cnt == RD_LAT - 2'd1) begin
            shreg    <= mem_q;
            baud_cnt <= '0;
            state    <= START_BIT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        START_BIT: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA_BITS;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        DATA_BITS: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP_BIT;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        STOP_BIT: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            state    <= NEXT;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        NEXT: begin
          if (byte_cnt == LENGTH - 16'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 16'd1;
            mem_addr <= mem_addr + 16'd1;  // wraps at 0xFFFF
            state    <= READ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_result_dumper.sv
module tb_dram_result_dumper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1, start2;
  logic [7:0]  q0, q1, q2, q2a;
  logic [15:0] addr0, addr1, addr2;
  logic wren0, wren1, wren2;
  logic tx0, tx1, tx2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  // LENGTH = 0 instance
  dram_result_dumper #(
    .START_ADDR(16'h0000), .LENGTH(16'd0), .CLKS_PER_BIT(16'd4), .RD_LAT(2'd1)
  ) u_len0 (
    .clock(clk), .rst(rst), .start(start0), .mem_q(q0), .mem_addr(addr0),
    .mem_wren(wren0), .tx(tx0), .busy(busy0), .done(done0)
  );

  // basic dump instance
  dram_result_dumper #(
    .START_ADDR(16'h0010), .LENGTH(16'd3), .CLKS_PER_BIT(16'd4), .RD_LAT(2'd1)
  ) u_basic (
    .clock(clk), .rst(rst), .start(start1), .mem_q(q1), .mem_addr(addr1),
    .mem_wren(wren1), .tx(tx1), .busy(busy1), .done(done1)
  );

  // address wrap instance, two-cycle read latency
  dram_result_dumper #(
    .START_ADDR(16'hFFFF), .LENGTH(16'd2), .CLKS_PER_BIT(16'd4), .RD_LAT(2'd2)
  ) u_wrap (
    .clock(clk), .rst(rst), .start(start2), .mem_q(q2), .mem_addr(addr2),
    .mem_wren(wren2), .tx(tx2), .busy(busy2), .done(done2)
  );

  // DRAM models
  function automatic logic [7:0] dram_basic(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hA5;
      16'h0011: return 8'h3C;
      16'h0012: return 8'hFF;
      default:  return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] dram_wrap(input logic [15:0] a);
    case (a)
      16'hFFFF: return 8'h01;
      16'h0000: return 8'h80;
      default:  return ~a[7:0];
    endcase
  endfunction

  assign q0 = 8'h77;
  always @(posedge clk) begin
    q1  <= dram_basic(addr1);
    q2a <= dram_wrap(addr2);
    q2  <= q2a;
  end

  // observed-instance mux
  int sel = 1;
  logic tx_m, busy_m, done_m;
  logic [15:0] addr_m;
  always_comb begin
    tx_m = tx1; busy_m = busy1; done_m = done1; addr_m = addr1;
    case (sel)
      0: begin tx_m = tx0; busy_m = busy0; done_m = done0; addr_m = addr0; end
      2: begin tx_m = tx2; busy_m = busy2; done_m = done2; addr_m = addr2; end
      default: ;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  // traces and scoreboard
  bit          tx_tr[$];
  bit          busy_tr[$];
  bit          done_tr[$];
  logic [15:0] addr_tr[$];
  logic [7:0]  exp_byte_q[$];
  int          exp_start_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int s, input logic v);
    case (s)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Start is high for the accepting edge (sample 0); afterwards it is high at
  // edge k when k <= hold_until or k == pulse_k. Sample k is taken 1 time unit
  // after edge k.
  task automatic capture(input int s, input int ncyc, input int hold_until, input int pulse_k);
    sel = s;
    tx_tr.delete(); busy_tr.delete(); done_tr.delete(); addr_tr.delete();
    drive_start(s, 1'b1);
    for (int k = 0; k < ncyc; k++) begin
      tick();
      tx_tr.push_back(tx_m);
      busy_tr.push_back(busy_m);
      done_tr.push_back(done_m);
      addr_tr.push_back(addr_m);
      drive_start(s, (k + 1 <= hold_until) || (k + 1 == pulse_k));
    end
    drive_start(s, 1'b0);
  endtask

  // Independent UART receiver over the captured tx trace, compared with the
  // scoreboard entries pushed when the stimulus was driven.
  task automatic check_frames(input string tag, input int cpb);
    int          fs[$];
    logic [7:0]  fb[$];
    bit          fstop[$];
    int          i;
    logic [7:0]  b;
    logic [7:0]  eb;
    int          es;
    i = 0;
    while (i + 10 * cpb <= tx_tr.size()) begin
      if (tx_tr[i] == 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = tx_tr[i + cpb * (j + 1) + cpb / 2];
        fs.push_back(i);
        fb.push_back(b);
        fstop.push_back(tx_tr[i + 9 * cpb + cpb / 2]);
        i = i + 10 * cpb;
      end else begin
        i++;
      end
    end
    chk({tag, "_nframes"}, fs.size(), exp_byte_q.size());
    while (exp_byte_q.size() > 0) begin
      eb = exp_byte_q.pop_front();
      es = exp_start_q.pop_front();
      if (fs.size() > 0) begin
        chk({tag, "_byte"}, fb.pop_front(), eb);
        chk({tag, "_start_cycle"}, fs.pop_front(), es);
        chk({tag, "_stop_bit"}, fstop.pop_front(), 1);
      end
    end
  endtask

  task automatic check_ctl(input string tag, input int exp_busy, input int exp_rises);
    int nb, nr;
    nb = 0; nr = 0;
    for (int k = 0; k < busy_tr.size(); k++) begin
      if (busy_tr[k]) nb++;
      if (done_tr[k] && (k == 0 || !done_tr[k - 1])) nr++;
    end
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_done_rises"}, nr, exp_rises);
    chk({tag, "_final_done"}, done_tr[done_tr.size() - 1], 1);
    chk({tag, "_final_busy"}, busy_tr[busy_tr.size() - 1], 0);
  endtask

  task automatic check_addr(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input int n);
    logic [15:0] seq[$];
    logic [15:0] ex[3];
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    for (int k = 0; k < addr_tr.size(); k++)
      if (busy_tr[k] && (seq.size() == 0 || seq[seq.size() - 1] != addr_tr[k]))
        seq.push_back(addr_tr[k]);
    chk({tag, "_addr_count"}, seq.size(), n);
    for (int k = 0; k < n && k < seq.size(); k++) chk({tag, "_addr_seq"}, seq[k], ex[k]);
  endtask

  task automatic push_basic(input int base);
    exp_byte_q.push_back(8'hA5); exp_start_q.push_back(base + 3);
    exp_byte_q.push_back(8'h3C); exp_start_q.push_back(base + 3 + 43);
    exp_byte_q.push_back(8'hFF); exp_start_q.push_back(base + 3 + 86);
  endtask

  initial begin
    int bad_tx, bad_busy, bad_done, bad_addr, nlow;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;

    // reset and idle
    tick(); tick();
    rst = 1'b0;
    bad_tx = 0; bad_busy = 0; bad_done = 0; bad_addr = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ({tx0, tx1, tx2} !== 3'b111) bad_tx++;
      if ({busy0, busy1, busy2} !== 3'b000) bad_busy++;
      if ({done0, done1, done2} !== 3'b000) bad_done++;
      if (addr0 !== 16'h0000) bad_addr++;
    end
    chk("rst_tx_idle", bad_tx, 0);
    chk("rst_busy_idle", bad_busy, 0);
    chk("rst_done_idle", bad_done, 0);
    chk("rst_addr_zero", bad_addr, 0);
    chk("rst_addr_basic", addr1, 16'h0010);
    chk("rst_addr_wrap", addr2, 16'hFFFF);
    chk("rst_wren", {wren0, wren1, wren2}, 3'b000);

    // basic dump, extra start pulse during byte 2 is ignored
    push_basic(0);
    capture(1, 134, 0, 60);
    check_frames("basic", 4);
    check_ctl("basic", 129, 1);
    check_addr("basic", 16'h0010, 16'h0011, 16'h0012, 3);

    // start held high: second dump begins the cycle after DONE
    push_basic(0);
    push_basic(130);
    capture(1, 265, 150, -1);
    check_frames("held", 4);
    check_ctl("held", 258, 2);
    chk("held_done_at_129", done_tr[129], 1);
    chk("held_busy_at_130", busy_tr[130], 1);

    // LENGTH = 0
    capture(0, 10, 0, -1);
    check_frames("len0", 4);
    nlow = 0;
    foreach (tx_tr[k]) if (!tx_tr[k]) nlow++;
    chk("len0_tx_low_cycles", nlow, 0);
    chk("len0_done_next_cycle", done_tr[0], 1);
    check_ctl("len0", 0, 1);

    // address wrap, RD_LAT = 2 (frame period 44, tx falls after 4 cycles)
    exp_byte_q.push_back(8'h01); exp_start_q.push_back(4);
    exp_byte_q.push_back(8'h80); exp_start_q.push_back(48);
    capture(2, 93, 0, -1);
    check_frames("wrap", 4);
    check_ctl("wrap", 88, 1);
    check_addr("wrap", 16'hFFFF, 16'h0000, 16'h0000, 2);

    // reset during DATA_BITS of byte 1 (bit 1 of 0xA5 is low)
    sel = 1;
    drive_start(1, 1'b1);
    tick();
    drive_start(1, 1'b0);
    for (int k = 1; k <= 11; k++) tick();
    chk("mid_tx_before_rst", tx1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_tx_after_rst", tx1, 1);
    chk("mid_busy_after_rst", busy1, 0);
    chk("mid_done_after_rst", done1, 0);
    chk("mid_addr_after_rst", addr1, 16'h0010);
    tick();
    push_basic(0);
    capture(1, 134, 0, -1);
    check_frames("restart", 4);
    check_ctl("restart", 129, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
